// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round sequencer: one shared round datapath reused for all NR rounds.
// Latency: ciphertext valid NR+1 cycles after the accept edge; one block per NR+2 cycles.
// Backpressure: result held in DONE until out_ready; no new block accepted until back in IDLE.
module aes_round_sequencer #(
    parameter int NR    = 10,
    parameter int BLK_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_key,
    input  logic [BLK_W-1:0] in_data,
    output logic [BLK_W-1:0] rnd_state,
    output logic [BLK_W-1:0] rnd_key,
    output logic [3:0]       rnd_idx,
    output logic             rnd_last,
    input  logic [BLK_W-1:0] rnd_state_nx,
    input  logic [BLK_W-1:0] rnd_key_nx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             busy
);

    localparam int CNT_W = $clog2(NR + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NR);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_q;
    logic [BLK_W-1:0] state_q;
    logic [BLK_W-1:0] key_q;
    logic [CNT_W-1:0] cnt_q;

    // Control FSM plus the state/key/round-counter registers it steers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone is the accept.
                    if (in_valid) begin
                        state_q <= in_data ^ in_key;
                        key_q   <= in_key;
                        cnt_q   <= CNT_ONE;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= rnd_state_nx;
                    key_q   <= rnd_key_nx;
                    // Counter parks at NR so it never wraps past the last round.
                    if (cnt_q == CNT_LAST) begin
                        fsm_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    // Handshake and sideband decode straight from the state register.
    always_comb begin
        in_ready  = (fsm_q == IDLE);
        out_valid = (fsm_q == DONE);
        busy      = (fsm_q == RUN) || (fsm_q == DONE);
        rnd_state = state_q;
        rnd_key   = key_q;
        out_data  = state_q;
        rnd_idx   = 4'd0;
        rnd_last  = 1'b0;
        if (fsm_q == RUN) begin
            rnd_idx  = 4'(cnt_q);
            rnd_last = (cnt_q == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies a behavioural AES round datapath, scoreboards ciphertexts.
// Latency: expectations are queued at stimulus time and popped on each output handshake.
// Backpressure: out_ready is stalled and released under test control.
module tb_aes_round_sequencer;

    localparam int NR = 10;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_data;
    logic [127:0] rnd_state;
    logic [127:0] rnd_key;
    logic [3:0]   rnd_idx;
    logic         rnd_last;
    logic [127:0] rnd_state_nx;
    logic [127:0] rnd_key_nx;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [127:0] exp_q[$];
    logic watch_abort = 1'b0;
    logic saw_abort_ov = 1'b0;

    aes_round_sequencer #(.NR(NR), .BLK_W(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_key       (in_key),
        .in_data      (in_data),
        .rnd_state    (rnd_state),
        .rnd_key      (rnd_key),
        .rnd_idx      (rnd_idx),
        .rnd_last     (rnd_last),
        .rnd_state_nx (rnd_state_nx),
        .rnd_key_nx   (rnd_key_nx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural AES round datapath ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        logic [15:0] t = {x, x};
        t = t << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] p = x;
        logic [7:0] e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ rol8(r, 1) ^ rol8(r, 2) ^ rol8(r, 3) ^ rol8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r = 8'h01;
        for (int i = 1; i < int'(idx); i++) r = xt(r);
        return r;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [3:0] idx);
        logic [31:0] w3 = k[31:0];
        logic [31:0] t;
        logic [31:0] w0n, w1n, w2n, w3n;
        t = {w3[23:0], w3[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rcon(idx), 24'h0};
        w0n = k[127:96] ^ t;
        w1n = k[95:64] ^ w0n;
        w2n = k[63:32] ^ w1n;
        w3n = k[31:0] ^ w2n;
        return {w0n, w1n, w2n, w3n};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] b[16];
        logic [7:0] t[16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[c*4+r] = b[((c + r) % 4)*4 + r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
                t[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    always_comb begin
        rnd_key_nx   = key_exp(rnd_key, rnd_idx);
        rnd_state_nx = aes_round(rnd_state, rnd_key_nx, rnd_last);
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every output handshake must match the oldest queued ciphertext.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check_eq("sb_pending", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) check_eq("ciphertext", out_data, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (watch_abort && out_valid) saw_abort_ov <= 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [127:0] k, input logic [127:0] d, input logic [127:0] c,
                        output int acc_cyc);
        bit ok = 1'b0;
        exp_q.push_back(c);
        in_key   = k;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
        end
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        check_eq("accept_timeout", 128'(ok), 128'(1));
    endtask

    task automatic wait_ov(output int n);
        bit ok = 1'b0;
        n = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check_eq("out_valid_timeout", 128'(ok), 128'(1));
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
        end
        check_eq("drain_timeout", 128'(ok), 128'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int a1, a2, n, rel_cyc;
        logic [127:0] hold;
        logic [127:0] dummy;
        in_valid  = 1'b0;
        in_key    = '0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_rnd_idx", 128'(rnd_idx), 128'(0));
        check_eq("rst_rnd_last", 128'(rnd_last), 128'(0));
        check_eq("rst_state", rnd_state, 128'(0));
        check_eq("rst_key", rnd_key, 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: FIPS-197 C.1 with latency check
        send(K1, P1, C1, a1);
        wait_ov(n);
        check_eq("t1_latency", 128'(n + 1), 128'(NR + 1));
        drain();

        // 2: FIPS-197 Appendix B
        send(K2, P2, C2, a1);
        drain();

        // 3: backpressure, with the next block waiting at the input
        out_ready = 1'b0;
        send(K1, P1, C1, a1);
        wait_ov(n);
        hold = out_data;
        in_key   = K2;
        in_data  = P2;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("t3_ov_held", 128'(out_valid), 128'(1));
            check_eq("t3_data_held", out_data, hold);
            check_eq("t3_in_ready_low", 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rel_cyc = cyc;
        send(K2, P2, C2, a2);
        check_eq("t3_accept_after_release", 128'(a2 - rel_cyc), 128'(2));
        drain();

        // 4: back-to-back blocks with in_valid held high
        send(K1, P1, C1, a1);
        send(K2, P2, C2, a2);
        check_eq("t4_accept_spacing", 128'(a2 - a1), 128'(NR + 2));
        drain();

        // 5: reset in the middle of RUN aborts the block
        send(K1, P1, C1, a1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        dummy = exp_q.pop_back();
        check_eq("t5_rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("t5_rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("t5_rst_busy", 128'(busy), 128'(0));
        check_eq("t5_rst_rnd_idx", 128'(rnd_idx), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        watch_abort = 1'b1;
        repeat (15) @(posedge clk);
        #1 watch_abort = 1'b0;
        check_eq("t5_no_out_valid", 128'(saw_abort_ov), 128'(0));
        check_eq("t5_idle_in_ready", 128'(in_ready), 128'(1));
        send(K2, P2, C2, a1);
        drain();

        // 6: round sideband, inputs toggled during RUN
        send(K1, P1, C1, a1);
        for (int i = 1; i <= NR; i++) begin
            @(negedge clk);
            check_eq("t6_rnd_idx", 128'(rnd_idx), 128'(i));
            check_eq("t6_rnd_last", 128'(rnd_last), 128'(i == NR));
            check_eq("t6_in_ready", 128'(in_ready), 128'(0));
            in_key  = ~in_key;
            in_data = ~in_data;
            @(posedge clk);
        end
        #1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
